// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver FSM states, baud constants.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // 3.226 MHz sampling clock / 115200 baud
  localparam int BAUD_115200_CLKS = 28;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Consumer-side bus of the UART receiver: FIFO head, handshake and error flags.
interface uart_frame_rx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]        o_data;
  logic                        o_valid;
  logic                        i_ready;
  logic                        i_clr_err;
  logic                        o_frame_err;
  logic                        o_parity_err;
  logic                        o_overflow;
  logic [$clog2(FIFO_DEPTH):0] o_count;

  modport master (
    output o_data, o_valid, o_frame_err, o_parity_err, o_overflow, o_count,
    input  i_ready, i_clr_err
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_parity_err, o_overflow, o_count,
    output i_ready, i_clr_err
  );
endinterface

// File: rtl/uart_frame_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        pop_ok, push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_frame_rx.sv
// UART receive front end: synchroniser, framing FSM with glitch rejection,
// parity/stop checking, and an output FIFO with valid/ready handshake.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = BAUD_115200_CLKS,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_rx,
  uart_frame_rx_if.master bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_M  = (PARITY == PAR_ODD);

  logic                 rx_m, rx_s;
  rx_state_e            state;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frame_err, parity_err;
  logic                 tick, push;
  logic                 fifo_full, fifo_empty, drop, overflow;

  // Two-flop synchroniser, preset to the idle-high line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (timer == T_FULL);

  // Push straight from the final good stop sample so the FIFO captures it on
  // that same edge and o_valid follows one cycle later.
  assign push = (state == RX_STOP) && tick && rx_s && (stop_cnt == S_LAST) && !par_err;

  // Frame FSM: bit timing, shifting, parity/stop checks, registered error pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_err  <= 1'b0;
          end
        end
        RX_START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            // a line back high at mid start bit was only a glitch
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            timer <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_PARITY: begin
          if (tick) begin
            timer   <= '0;
            par_err <= ((^shreg) ^ rx_s) != ODD_M;
            state   <= RX_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick) begin
            timer <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_IDLE;
            end else if (stop_cnt == S_LAST) begin
              parity_err <= par_err;
              state      <= RX_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          // need one full bit time of idle-high before hunting for a start
          if (!rx_s) begin
            timer <= '0;
          end else if (tick) begin
            timer <= '0;
            state <= RX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (bus.i_ready),
    .pop_data  (bus.o_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (bus.o_count)
  );

  assign drop = push && fifo_full && !(bus.i_ready && !fifo_empty);

  // Sticky overflow; a new drop beats a same-cycle clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
    else if (bus.i_clr_err) overflow <= 1'b0;
  end

  assign bus.o_valid      = !fifo_empty;
  assign bus.o_frame_err  = frame_err;
  assign bus.o_parity_err = parity_err;
  assign bus.o_overflow   = overflow;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench: an 8N1 receiver (dut_n) and an 8E1 receiver (dut_p).
// Stimulus pushes expected bytes/error events; negedge monitors pop and compare.
module tb_uart_frame_rx;
  import uart_pkg::*;
  localparam int CPB = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_n = 1'b1, rx_p = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   lat = -1;
  bit   meas = 1'b0;
  logic vprev = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   dat_n[$], dat_p[$], err_n[$], err_p[$];

  uart_frame_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_n ();
  uart_frame_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_p ();

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_NONE)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_n), .bus(bus_n));
  uart_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_p), .bus(bus_p));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic take(input string name, inout int q[$], input int act);
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // Monitor: every handshake and every error pulse must match the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_n.o_valid && bus_n.i_ready) take("pop_n", dat_n, int'(bus_n.o_data));
      if (bus_p.o_valid && bus_p.i_ready) take("pop_p", dat_p, int'(bus_p.o_data));
      if (bus_n.o_frame_err)  take("ferr_n", err_n, 1);
      if (bus_n.o_parity_err) take("perr_n", err_n, 2);
      if (bus_p.o_frame_err)  take("ferr_p", err_p, 1);
      if (bus_p.o_parity_err) take("perr_p", err_p, 2);
      if (meas && bus_n.o_valid && !vprev) begin
        lat  = cyc - t0;
        meas = 1'b0;
      end
      vprev = bus_n.o_valid;
    end
  end

  // One frame: start, nd data bits LSB first, optional parity, one stop bit
  task automatic send(input bit p, input logic [8:0] data, input int nd,
                      input bit has_par, input bit par, input bit stop);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < nd; i++) begin bits[n] = data[i]; n++; end
    if (has_par) begin bits[n] = par; n++; end
    bits[n] = stop;
    n++;
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (p) rx_p = bits[i]; else rx_n = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (p) rx_p = 1'b1; else rx_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_data"},  int'(bus_n.o_data), 0);
    check({tag, "_valid"}, int'(bus_n.o_valid), 0);
    check({tag, "_count"}, int'(bus_n.o_count), 0);
    check({tag, "_ferr"},  int'(bus_n.o_frame_err), 0);
    check({tag, "_perr"},  int'(bus_n.o_parity_err), 0);
    check({tag, "_ovf"},   int'(bus_n.o_overflow), 0);
  endtask

  initial begin
    bus_n.i_ready = 1'b0; bus_n.i_clr_err = 1'b0;
    bus_p.i_ready = 1'b1; bus_p.i_clr_err = 1'b0;
    #1;
    chk_zero("reset");
    check("reset_count_p", int'(bus_p.o_count), 0);
    idle(3);
    rst_n = 1'b1;
    idle(5);

    // 1: 8N1 0xA5. Stop-bit centre is cycle 9*28+14=266, +2 synchroniser, +1
    // register stage -> o_valid first seen 269 edges after the start edge.
    bus_n.i_ready = 1'b1;
    dat_n.push_back(8'hA5);
    meas = 1'b1;
    send(0, 9'hA5, 8, 0, 0, 1);
    idle(40);
    check("latency", lat, 269);

    // 2: 5-cycle glitch must vanish without output or error
    rx_n = 1'b0; idle(5); rx_n = 1'b1;
    idle(100);
    check("glitch_valid", int'(bus_n.o_valid), 0);
    check("glitch_count", int'(bus_n.o_count), 0);

    // 3: stop low -> one frame error; a 100-cycle low line is not a new frame
    bus_n.i_ready = 1'b0;
    err_n.push_back(1);
    send(0, 9'h3C, 8, 0, 0, 0);
    rx_n = 1'b0; idle(100); rx_n = 1'b1;
    idle(2 * CPB);
    check("ferr_count", int'(bus_n.o_count), 0);
    dat_n.push_back(8'h11);
    send(0, 9'h11, 8, 0, 0, 1);
    idle(20);
    check("after_ferr_count", int'(bus_n.o_count), 1);
    bus_n.i_ready = 1'b1;
    idle(5);

    // 4: even parity, 0x07 has three ones -> parity bit must be 1
    err_p.push_back(2);
    send(1, 9'h07, 8, 1, 0, 1);
    idle(20);
    check("perr_count_p", int'(bus_p.o_count), 0);
    dat_p.push_back(8'h07);
    send(1, 9'h07, 8, 1, 1, 1);
    idle(20);

    // 5: overflow with consumer stalled
    bus_n.i_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) dat_n.push_back(b);
      send(0, 9'(b), 8, 0, 0, 1);
      idle(10);
    end
    check("ovf_count", int'(bus_n.o_count), 4);
    check("ovf_flag", int'(bus_n.o_overflow), 1);
    bus_n.i_ready = 1'b1;
    idle(10);
    check("drain_count", int'(bus_n.o_count), 0);
    check("ovf_sticky", int'(bus_n.o_overflow), 1);
    bus_n.i_clr_err = 1'b1; idle(1); bus_n.i_clr_err = 1'b0;
    check("ovf_clr", int'(bus_n.o_overflow), 0);

    // 6: full FIFO, ready pulsed exactly on the push cycle of 0x66
    bus_n.i_ready = 1'b0;
    for (int b = 8'h21; b <= 8'h24; b++) begin
      dat_n.push_back(b);
      send(0, 9'(b), 8, 0, 0, 1);
      idle(10);
    end
    check("full_count", int'(bus_n.o_count), 4);
    dat_n.push_back(8'h66);
    fork
      send(0, 9'h66, 8, 0, 0, 1);
      begin
        @(posedge clk);
        repeat (268) @(posedge clk);
        #1 bus_n.i_ready = 1'b1;
        @(posedge clk);
        #1 bus_n.i_ready = 1'b0;
      end
    join
    idle(5);
    check("simul_count", int'(bus_n.o_count), 4);
    check("simul_ovf", int'(bus_n.o_overflow), 0);
    bus_n.i_ready = 1'b1;
    idle(10);
    check("simul_drain", int'(bus_n.o_count), 0);

    // Reset mid-frame with one entry queued: everything clears at once
    bus_n.i_ready = 1'b0;
    dat_n.push_back(8'h5A);
    send(0, 9'h5A, 8, 0, 0, 1);
    idle(10);
    check("pre_rst_count", int'(bus_n.o_count), 1);
    fork
      send(0, 9'h55, 8, 0, 0, 1);
      begin
        idle(100);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        dat_n.delete();
      end
    join
    // Release with the line already low: taken as the start of a 0x00 frame
    rx_n = 1'b0;
    idle(2);
    bus_n.i_ready = 1'b1;
    dat_n.push_back(8'h00);
    idle(1);
    rst_n = 1'b1;
    repeat (9 * CPB - 1) @(posedge clk);
    #1 rx_n = 1'b1;
    idle(2 * CPB);

    check("left_n", dat_n.size() + err_n.size(), 0);
    check("left_p", dat_p.size() + err_p.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Parametrised UART receive front end that replaces the fixed 8N1 receiver feeding the controller-command parser.
- Adds configurable word width, parity mode, bit timing, glitch rejection and frame/parity error reporting.
- Adds a small output FIFO with valid/ready handshake, so bursts of controller bytes are not lost while the game logic is busy.
- Sits between the GPIO UART pin and the command parser, in the UART clock domain.

Parameters:
CLKS_PER_BIT, 28, i_clk cycles per UART bit (3.226 MHz / 115200); must be >= 4
DATA_BITS, 8, payload bits per frame, 5..9, LSB first
PARITY, PAR_NONE, parity mode from uart_pkg: PAR_NONE, PAR_ODD, PAR_EVEN
STOP_BITS, 1, stop bits checked, 1 or 2
FIFO_DEPTH, 4, output FIFO entries, power of two >= 2

Ports:
i_clk  in  1  UART sampling clock
i_rst_n  in  1  asynchronous active-low reset
i_rx  in  1  raw serial line, idle high, asynchronous to i_clk
i_ready  in  1  consumer accepts the head entry this cycle
i_clr_err  in  1  clears o_overflow
o_data  out  DATA_BITS  FIFO head payload
o_valid  out  1  FIFO non-empty
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_parity_err  out  1  one-cycle pulse: parity mismatch
o_overflow  out  1  sticky: a good frame was dropped because the FIFO was full
o_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync use after release):
  - o_data=0, o_valid=0, all error outputs 0, o_count=0.
  - FSM in IDLE; both synchroniser flops preset to 1.
- Input: 2-flop synchroniser on i_rx; all logic uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: rx_s=0 -> START, bit counter cleared, timer cleared.
- START: timer reaches CLKS_PER_BIT/2-1 (mid start bit).
  - rx_s=1 -> glitch; IDLE, no error.
  - rx_s=0 -> DATA, timer reset.
- DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first.
  - After DATA_BITS samples: PARITY if PARITY!=PAR_NONE, else STOP.
- PARITY: one sample.
  - Odd mode: XOR of data bits and parity bit must be 1.
  - Even mode: the same XOR must be 0.
  - Mismatch is latched as an error flag for this frame.
- STOP: STOP_BITS samples, each must be 1.
  - Any stop sample 0 -> o_frame_err pulses on that sample's cycle; frame discarded; WAIT_IDLE.
  - All stop samples 1 and parity flag set -> o_parity_err pulses on the last stop-sample cycle; frame discarded; IDLE.
  - All stop samples 1 and parity good -> push request on the last stop-sample cycle; IDLE.
- WAIT_IDLE: stay until rx_s=1 for one full CLKS_PER_BIT, then IDLE. This avoids resyncing inside a break or noise burst.
- Latency: with the FIFO empty, o_valid rises 1 cycle after the final stop-bit sample cycle, with o_data valid.
- FIFO (first-word-fall-through):
  - Pop occurs when o_valid && i_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the byte is dropped and o_overflow is set.
- Simultaneous push and pop: o_count unchanged; ordering preserved.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; full/empty come from o_count.
- o_overflow: cleared by i_clr_err. If i_clr_err and a new overflow occur in the same cycle, the set wins.
- i_ready while empty: ignored.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied. After release, a line held low is treated as a new start edge.

Decomposition:
- uart_pkg holds:
  - typedef enum parity_e {PAR_NONE, PAR_ODD, PAR_EVEN}
  - typedef enum rx_state_e (the six FSM states)
  - localparam BAUD_115200_CLKS = 28
- One sub-module: sync_fifo, parametrised on WIDTH and DEPTH, with push/pop/full/empty/count. It is reusable for the future TX path.
- Synchroniser and FSM stay inline.

Test Plan:
1. 8N1 defaults: send frame 0xA5, hold i_ready=1 -> o_valid high exactly 1 cycle after the stop mid-sample, o_data=0xA5, no errors.
2. Start glitch: pull i_rx low for 5 cycles, then high -> FSM returns to IDLE; no o_valid, no error pulse.
3. Stop bit low: send 0x3C with stop=0 -> o_frame_err single pulse; FIFO unchanged. Then line low 100 cycles, high, then 0x11 -> exactly one entry 0x11.
4. PARITY=PAR_EVEN, send 0x07 with parity bit 0 -> o_parity_err pulse, nothing pushed. Same byte with parity 1 -> 0x07 pushed.
5. Overflow: i_ready=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> o_count=4, o_overflow=1. Pops yield 0x01..0x04. i_clr_err clears o_overflow.
6. Full with simultaneous pop: FIFO full, pulse i_ready on the push cycle of 0x66 -> o_count stays 4; 0x66 is last out. Then assert i_rst_n=0 mid-frame -> all outputs 0 immediately.
